ex_muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer beside the EXECUTE stage ALU. Takes RV32M

---
 rtl/ex_muldiv_seq.sv | 148 ++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M unsigned multiply/divide unit beside the EX-stage ALU.
// Shift-add multiply and restoring divide, one iteration per enabled cycle.
module ex_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] work_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] result_q;
  logic            busy_q;
  logic            valid_q;

  logic                   accept;
  logic                   div_zero;
  logic [XLEN:0]          mul_sum;
  logic [XLEN-1:0]        mul_acc_d;
  logic [XLEN-1:0]        mul_work_d;
  logic [XLEN:0]          rem_sh;
  logic signed [XLEN+1:0] trial;
  logic                   div_ge;
  logic [XLEN-1:0]        div_acc_d;
  logic [XLEN-1:0]        div_work_d;
  logic [XLEN-1:0]        acc_d;
  logic [XLEN-1:0]        work_d;
  logic [XLEN-1:0]        fin_result;
  logic                   unused_trial_bit;

  // acc holds product-high / remainder, work holds multiplier-low / quotient,
  // opnd holds multiplicand / divisor for the whole operation.
  always_comb begin
    accept   = (state_q == IDLE) && start_i && !flush_i;
    div_zero = op_i[1] && (op2_i == '0);

    mul_sum    = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc_d  = mul_sum[XLEN:1];
    mul_work_d = {mul_sum[0], work_q[XLEN-1:1]};

    rem_sh     = {acc_q, work_q[XLEN-1]};
    trial      = $signed({1'b0, rem_sh}) - $signed({2'b00, opnd_q});
    div_ge     = !trial[XLEN+1];
    div_acc_d  = div_ge ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_work_d = {work_q[XLEN-2:0], div_ge};

    acc_d  = op_q[1] ? div_acc_d  : mul_acc_d;
    work_d = op_q[1] ? div_work_d : mul_work_d;
    // op[0] selects the high half (MULHU) or remainder (REMU)
    fin_result = op_q[0] ? acc_d : work_d;

    stall_o = accept || ((state_q == RUN) && !flush_i);
  end

  // A non-negative trial implies its bit XLEN is clear, so only the low bits are kept.
  assign unused_trial_bit = trial[XLEN];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else if (EN) begin
      if (flush_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              op_q   <= op_i;
              cnt_q  <= CNT_INIT;
              acc_q  <= '0;
              work_q <= op_i[1] ? op1_i : op2_i;
              opnd_q <= op_i[1] ? op2_i : op1_i;
              busy_q <= 1'b1;
              if (div_zero) begin
                state_q  <= DONE;
                valid_q  <= 1'b1;
                result_q <= op_i[0] ? op1_i : '1;
              end else begin
                state_q <= RUN;
                valid_q <= 1'b0;
              end
            end
          end
          RUN: begin
            acc_q  <= acc_d;
            work_q <= work_d;
            if (cnt_q == '0) begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              result_q <= fin_result;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          DONE: begin
            // The instruction is still in EX this cycle; start_i must not re-trigger.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed table, hand-written corner
// sequences and randomized ops against an arithmetic reference model.
module tb_ex_muldiv_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        flush_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        busy_o;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .flush_i  (flush_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
    return (op[1] && b == 0) ? 1 : 33;
  endfunction

  // Observes from the current cycle (start already driven) for a bounded window.
  task automatic track(input int en_at, input int en_len, output logic [31:0] res,
                       output int lat, output int stalls, output int pulses);
    bit seen;
    seen = 1'b0;
    res = '0; lat = -1; stalls = 0; pulses = 0;
    for (int c = 0; c < 70; c++) begin
      #1;
      if (stall_o) stalls++;
      if (valid_o) begin
        pulses++;
        if (!seen) begin
          seen = 1'b1;
          lat  = c;
          res  = result_o;
        end
      end
      @(negedge CLK);
      if (seen) start_i = 1'b0;
      op_i  = 2'($urandom);
      op1_i = $urandom;
      op2_i = $urandom;
      if (c + 1 == en_at) EN = 1'b0;
      if (c + 1 == en_at + en_len) EN = 1'b1;
    end
    start_i = 1'b0;
    EN = 1'b1;
  endtask

  task automatic run_vec(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat, st, pu;
    @(negedge CLK);
    start_i = 1'b1; op_i = op; op1_i = a; op2_i = b;
    track(-1, 0, res, lat, st, pu);
    check({name, ".result"}, res, exp);
    check({name, ".latency"}, lat, exp_lat);
    check({name, ".stalls"}, st, exp_lat);
    check({name, ".pulses"}, pu, 1);
  endtask

  vec_t vecs[15];

  initial begin
    logic [31:0] res, a, b;
    logic [1:0]  op;
    int lat, st, pu;

    vecs[0]  = '{2'd0, 32'd7,          32'd6,          32'd42,         33};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33};
    vecs[2]  = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33};
    vecs[3]  = '{2'd2, 32'd100,        32'd7,          32'd14,         33};
    vecs[4]  = '{2'd3, 32'd100,        32'd7,          32'd2,          33};
    vecs[5]  = '{2'd2, 32'd5,          32'd9,          32'd0,          33};
    vecs[6]  = '{2'd3, 32'd5,          32'd9,          32'd5,          33};
    vecs[7]  = '{2'd2, 32'h1234,       32'd0,          32'hFFFF_FFFF,  1};
    vecs[8]  = '{2'd3, 32'h1234,       32'd0,          32'h1234,       1};
    vecs[9]  = '{2'd0, 32'h8000_0000,  32'd2,          32'd0,          33};
    vecs[10] = '{2'd1, 32'h8000_0000,  32'd2,          32'd1,          33};
    vecs[11] = '{2'd2, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[12] = '{2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[13] = '{2'd1, 32'h1234_5678,  32'h10,         32'd1,          33};
    vecs[14] = '{2'd0, 32'h0001_0001,  32'h0001_0001,  32'h0002_0001,  33};

    RST = 1'b1; EN = 1'b1; flush_i = 1'b0; start_i = 1'b0;
    op_i = '0; op1_i = '0; op2_i = '0;
    repeat (3) @(negedge CLK);
    #1;
    check("reset.busy",   busy_o,   0);
    check("reset.stall",  stall_o,  0);
    check("reset.valid",  valid_o,  0);
    check("reset.result", result_o, 0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 15; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Flush at RUN iteration 10, then a new start the following cycle.
    @(negedge CLK);
    start_i = 1'b1; op_i = 2'd0; op1_i = 32'd3; op2_i = 32'd5;
    repeat (10) @(negedge CLK);
    flush_i = 1'b1;
    #1;
    check("flush.stall_same_cycle", stall_o, 0);
    @(negedge CLK);
    flush_i = 1'b0; op_i = 2'd2; op1_i = 32'd1000; op2_i = 32'd10;
    #1;
    check("flush.busy_after",   busy_o,   0);
    check("flush.valid_after",  valid_o,  0);
    check("flush.result_held",  result_o, vecs[14].exp);
    check("flush.restart_stall", stall_o, 1);
    track(-1, 0, res, lat, st, pu);
    check("flush.new_result",  res, 32'd100);
    check("flush.new_latency", lat, 33);
    check("flush.new_pulses",  pu, 1);

    // Flush wins over a simultaneous start in IDLE.
    @(negedge CLK);
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'd0; op1_i = 32'd9; op2_i = 32'd9;
    #1;
    check("flushstart.stall", stall_o, 0);
    @(negedge CLK);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check("flushstart.busy", busy_o, 0);

    // EN low for 5 cycles mid-RUN delays valid by exactly 5.
    @(negedge CLK);
    start_i = 1'b1; op_i = 2'd0; op1_i = 32'h1234; op2_i = 32'h100;
    track(10, 5, res, lat, st, pu);
    check("enlow.result",  res, 32'h0012_3400);
    check("enlow.latency", lat, 38);
    check("enlow.pulses",  pu, 1);

    // EN low while in DONE keeps valid high.
    @(negedge CLK);
    start_i = 1'b1; op_i = 2'd2; op1_i = 32'h1234; op2_i = 32'd0;
    track(1, 3, res, lat, st, pu);
    check("endone.result",      res, 32'hFFFF_FFFF);
    check("endone.latency",     lat, 1);
    check("endone.valid_cycles", pu, 4);

    // Reset in the middle of RUN clears all outputs at once.
    @(negedge CLK);
    start_i = 1'b1; op_i = 2'd0; op1_i = 32'h55; op2_i = 32'd3;
    repeat (10) @(negedge CLK);
    RST = 1'b1; start_i = 1'b0;
    #1;
    check("rstmid.busy",   busy_o,   0);
    check("rstmid.stall",  stall_o,  0);
    check("rstmid.valid",  valid_o,  0);
    check("rstmid.result", result_o, 0);
    @(negedge CLK);
    RST = 1'b0;
    track(-1, 0, res, lat, st, pu);
    check("rstmid.no_valid", pu, 0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = $urandom_range(1, 300);
        4:       b = a;
        default: b = $urandom;
      endcase
      run_vec($sformatf("rand%0d", i), op, a, b, model(op, a, b), model_lat(op, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
